// File: rtl/qam_mixer_if.sv
// rtl/qam_mixer_if.sv - modulator-to-mixer bundle: strobes, levels, carriers and mixer results
interface qam_mixer_if #(
  parameter int LW   = 3,
  parameter int CW   = 10,
  parameter int OW   = 13,
  parameter int ERRW = 8
);
  logic                   clk_CarryWave;
  logic                   clk_level;
  logic                   m_align;
  logic signed [LW-1:0]   Siga;
  logic signed [LW-1:0]   Sigb;
  logic        [CW-1:0]   CosWave;
  logic        [CW-1:0]   SinWave;
  logic signed [OW-1:0]   QamOut;
  logic        [CW-1:0]   DacOut;
  logic                   out_valid;
  logic                   running;
  logic        [ERRW-1:0] align_err;

  modport master (
    output clk_CarryWave, clk_level, m_align, Siga, Sigb, CosWave, SinWave,
    input  QamOut, DacOut, out_valid, running, align_err
  );

  modport slave (
    input  clk_CarryWave, clk_level, m_align, Siga, Sigb, CosWave, SinWave,
    output QamOut, DacOut, out_valid, running, align_err
  );
endinterface

// File: rtl/qam_mixer.sv
// rtl/qam_mixer.sv - strobe-gated 3-stage QAM mixer (y = a*cos - b*sin) with alignment FSM
// Optional QAM_GAIN2_EN: +6 dB DAC scaling with clipping; default is a plain >>>3 mapping.
module qam_mixer #(
  parameter int LW   = 3,
  parameter int CW   = 10,
  parameter int OW   = 13,
  parameter int ERRW = 8
) (
  input  logic           clk,
  input  logic           rst,
  qam_mixer_if.slave     bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               state;
  logic signed [LW-1:0]     a_h, b_h, s1_a, s1_b;
  logic signed [CW-1:0]     s1_c, s1_s, c_in, s_in;
  logic signed [LW+CW-1:0]  s2_p, s2_q;
  logic                     run_enter, align_loss, advance;

  // Offset-binary to two's complement is just an MSB flip
  assign c_in = {~bus.CosWave[CW-1], bus.CosWave[CW-2:0]};
  assign s_in = {~bus.SinWave[CW-1], bus.SinWave[CW-2:0]};

  assign run_enter  = (state == IDLE) && bus.clk_level && bus.m_align;
  assign align_loss = (state == RUN)  && bus.clk_level && !bus.m_align;
  assign advance    = (state == RUN)  && bus.clk_CarryWave && !align_loss;

  assign bus.running = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      a_h           <= '0;
      b_h           <= '0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_c          <= '0;
      s1_s          <= '0;
      s2_p          <= '0;
      s2_q          <= '0;
      bus.QamOut    <= '0;
      bus.out_valid <= 1'b0;
      bus.align_err <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      // Stage 1 reads the pre-edge hold value, so a coincident symbol waits one strobe
      if (bus.clk_level) begin
        a_h <= bus.Siga;
        b_h <= bus.Sigb;
      end
      if (run_enter) begin
        state <= RUN;
      end
      if (align_loss) begin
        state      <= IDLE;
        s1_a       <= '0;
        s1_b       <= '0;
        s1_c       <= '0;
        s1_s       <= '0;
        s2_p       <= '0;
        s2_q       <= '0;
        bus.QamOut <= '0;
        if (bus.align_err != '1) begin
          bus.align_err <= bus.align_err + ERRW'(1);
        end
      end else if (advance) begin
        s1_a          <= a_h;
        s1_b          <= b_h;
        s1_c          <= c_in;
        s1_s          <= s_in;
        s2_p          <= s1_a * s1_c;
        s2_q          <= s1_b * s1_s;
        bus.QamOut    <= OW'(s2_p) - OW'(s2_q);
        bus.out_valid <= 1'b1;
      end
    end
  end

`ifdef QAM_GAIN2_EN
  // Thresholds in QamOut units where (QamOut >>> 2) leaves the signed CW-bit range
  localparam logic signed [OW-1:0] G_HI = OW'((1 << (CW + 1)) - 1);
  localparam logic signed [OW-1:0] G_LO = ~G_HI;

  always_comb begin
    bus.DacOut = {~bus.QamOut[CW+1], bus.QamOut[CW:2]};
    if (bus.QamOut > G_HI) begin
      bus.DacOut = '1;
    end else if (bus.QamOut < G_LO) begin
      bus.DacOut = '0;
    end
  end
`else
  assign bus.DacOut = {~bus.QamOut[CW+2], bus.QamOut[CW+1:3]};
`endif
endmodule

// File: tb/tb_qam_mixer.sv
// tb/tb_qam_mixer.sv - directed self-checking bench for qam_mixer
module tb_qam_mixer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   vc_snap;

`ifdef QAM_GAIN2_EN
  localparam int DAC_511  = 639;
  localparam int DAC_1533 = 895;
`else
  localparam int DAC_511  = 575;
  localparam int DAC_1533 = 703;
`endif

  always #5 clk = ~clk;

  qam_mixer_if bus ();

  qam_mixer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.out_valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic lvl, input logic cw);
    bus.clk_level     = lvl;
    bus.clk_CarryWave = cw;
    @(posedge clk);
    #1;
    bus.clk_level     = 1'b0;
    bus.clk_CarryWave = 1'b0;
  endtask

  task automatic set_sym(input logic signed [2:0] a, input logic signed [2:0] b,
                         input logic [9:0] cosw, input logic [9:0] sinw);
    bus.Siga    = a;
    bus.Sigb    = b;
    bus.CosWave = cosw;
    bus.SinWave = sinw;
  endtask

  initial begin
    bus.clk_level     = 1'b0;
    bus.clk_CarryWave = 1'b0;
    bus.m_align       = 1'b0;
    set_sym(3'sd0, 3'sd0, 10'd512, 10'd512);

    repeat (3) @(posedge clk);
    #1;
    check("rst_running",   bus.running,   0);
    check("rst_qam",       $signed(bus.QamOut), 0);
    check("rst_dac",       bus.DacOut,    512);
    check("rst_valid",     bus.out_valid, 0);
    check("rst_align_err", bus.align_err, 0);

    rst = 1'b1;
    set_sym(3'sd1, 3'sd0, 10'd1023, 10'd512);
    repeat (4) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
    end
    tick(1'b0, 1'b0);
    check("idle_running",   bus.running,   0);
    check("idle_qam",       $signed(bus.QamOut), 0);
    check("idle_dac",       bus.DacOut,    512);
    check("idle_valid_cnt", valid_cnt,     0);
    check("idle_align_err", bus.align_err, 0);

    bus.m_align = 1'b1;
    tick(1'b1, 1'b0);
    check("enter_running", bus.running, 1);
    tick(1'b0, 1'b1);
    check("first_valid", bus.out_valid, 1);
    check("first_qam",   $signed(bus.QamOut), 0);
    tick(1'b0, 1'b0);
    check("valid_drop",  bus.out_valid, 0);
    tick(1'b0, 1'b1);
    check("second_qam",  $signed(bus.QamOut), 0);
    tick(1'b0, 1'b1);
    check("a1_valid",    bus.out_valid, 1);
    check("a1_qam",      $signed(bus.QamOut), 511);
    check("a1_dac",      bus.DacOut, DAC_511);

    set_sym(-3'sd4, -3'sd4, 10'd0, 10'd1023);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    check("pos_full_qam", $signed(bus.QamOut), 4092);
    check("pos_full_dac", bus.DacOut, 1023);

    set_sym(-3'sd4, -3'sd4, 10'd1023, 10'd0);
    repeat (3) tick(1'b0, 1'b1);
    check("neg_full_qam", $signed(bus.QamOut), -4092);
    check("neg_full_dac", bus.DacOut, 0);

    set_sym(3'sd1, 3'sd0, 10'd1023, 10'd512);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    check("pre_coinc_qam", $signed(bus.QamOut), 511);
    bus.Siga = 3'sd3;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("coinc_extra_qam", $signed(bus.QamOut), 511);
    tick(1'b0, 1'b1);
    check("coinc_new_qam", $signed(bus.QamOut), 1533);
    check("coinc_new_dac", bus.DacOut, DAC_1533);

    bus.m_align = 1'b0;
    tick(1'b1, 1'b0);
    check("loss_running",   bus.running,   0);
    check("loss_qam",       $signed(bus.QamOut), 0);
    check("loss_dac",       bus.DacOut,    512);
    check("loss_align_err", bus.align_err, 1);
    tick(1'b0, 1'b0);
    vc_snap = valid_cnt;
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("loss_no_valid", valid_cnt, vc_snap);
    check("loss_hold_qam", $signed(bus.QamOut), 0);

    bus.m_align = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("reenter_flushed_qam", $signed(bus.QamOut), 0);
    bus.m_align = 1'b0;
    tick(1'b1, 1'b0);
    check("loss2_align_err", bus.align_err, 2);
    repeat (298) begin
      bus.m_align = 1'b1;
      tick(1'b1, 1'b0);
      bus.m_align = 1'b0;
      tick(1'b1, 1'b0);
    end
    check("sat_align_err", bus.align_err, 255);

    bus.m_align = 1'b1;
    tick(1'b1, 1'b0);
    check("pre_rst_running", bus.running, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_running",   bus.running,   0);
    check("async_rst_align_err", bus.align_err, 0);
    check("async_rst_dac",       bus.DacOut,    512);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qam_mixer.md
Name: qam_mixer

Overview:
- Downstream stage of DigitalQAMModulation; consumes its level outputs (Siga/Sigb), carrier samples (SinWave/CosWave), strobes and m_align.
- Forms the passband QAM sample y = a·cos − b·sin through a strobe-gated 3-stage pipeline.
- Emits a signed full-precision sample and a 10-bit offset-binary DAC word.
- Contains an alignment FSM that mutes output until the modulator is frame-aligned and counts alignment losses.

Parameters:
- LW, 3, level width (Siga/Sigb, two's complement).
- CW, 10, carrier sample width (offset binary, midscale 512).
- OW, 13, QamOut width; must be ≥ LW+CW.
- ERRW, 8, align-error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_CarryWave  in  1  carrier sample strobe, sampled synchronously; pipeline advances on clk edges where it is high.
- clk_level  in  1  symbol strobe, sampled synchronously.
- m_align  in  1  modulator frame-alignment flag.
- Siga  in  LW  in-phase level, two's complement.
- Sigb  in  LW  quadrature level, two's complement.
- CosWave  in  CW  cosine carrier sample, offset binary.
- SinWave  in  CW  sine carrier sample, offset binary.
- QamOut  out  OW  signed mixed sample.
- DacOut  out  CW  offset-binary DAC word.
- out_valid  out  1  one-clk pulse when QamOut/DacOut update.
- running  out  1  high in RUN state.
- align_err  out  ERRW  saturating count of alignment losses.

Behaviour:
- Reset (rst low, async): state = IDLE; pipeline regs = 0; QamOut = 0; DacOut = 512; out_valid = 0; align_err = 0.
- Carrier conversion: signed c = {~CosWave[9], CosWave[8:0]}; s likewise. Range −512..511.
- Symbol hold: a_h/b_h capture Siga/Sigb on clk_level. A new symbol enters stage 1 on the next clk_CarryWave.
- Stage 1, on clk_CarryWave: register a_h, b_h, c, s.
- Stage 2, on clk_CarryWave: register p = a·c, q = b·s (13-bit signed each).
- Stage 3, on clk_CarryWave: register QamOut = p − q. Range ±4092, no overflow.
- DacOut = (QamOut >>> 3) + 512, truncated to 10 bits (arithmetic shift, floor). Range 0..1023.
- Latency: a sample presented at strobe k appears on QamOut after the clk edge of strobe k+2.
- out_valid is high for the clk following each stage-3 update in RUN; it is never high in IDLE.
- FSM:
  - IDLE: on clk_level with m_align = 1, go to RUN. Pipeline and outputs held at reset values.
  - RUN: on clk_level with m_align = 0, go to IDLE. Flush pipeline to 0, QamOut = 0, DacOut = 512. Increment align_err, saturating at 255.
  - m_align changes between symbol strobes are ignored.
- Simultaneous clk_level and clk_CarryWave: stage 1 captures the old a_h/b_h; the new symbol enters on the next strobe.
- First two valid outputs after entering RUN come from flushed zeros: QamOut = 0.
- Reset mid-operation returns to IDLE immediately. align_err clears only on reset.

Optional Feature:
- QAM_GAIN2_EN defined:
  - DacOut = sat(QamOut >>> 2, −512..511) + 512.
  - +6 dB gain; clips to 0/1023 beyond full scale.
- Undefined: shift by 3, no saturation logic, as in Behaviour.

Test Plan:
- Reset release, strobes running, m_align = 0 -> running = 0, QamOut = 0, DacOut = 512, out_valid never high, align_err = 0.
- m_align = 1, a = 1, b = 0, CosWave = 1023 constant -> RUN. After 3 strobes QamOut = 511, DacOut = 575, out_valid pulses once per strobe.
- a = −4, b = −4, CosWave = 0, SinWave = 1023 -> QamOut = 4092, DacOut = 1023. Mirror case (CosWave = 1023, SinWave = 0) -> QamOut = −4092, DacOut = 0.
- In RUN, m_align dropped at a clk_level -> next clk: running = 0, QamOut = 0, DacOut = 512, align_err = 1. Repeat 300 times -> align_err = 255.
- clk_level and clk_CarryWave coincident with a symbol change from 1 to 3 (CosWave = 1023, b = 0) -> QamOut shows 511 for one extra strobe, then 1533.
- QAM_GAIN2_EN with QamOut = 4092 -> DacOut = 1023 (saturated). With QamOut = 400 -> DacOut = 612.
